aes_blk_loader: RTL



---
 rtl/aes_pkg.sv | 29 ++
 rtl/aes_blk_fifo.sv | 83 ++++++++
 rtl/aes_blk_loader.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// ============================================================================
// Module      : aes_pkg
// Description : Shared types for the AES block loader: block width, block
//               type, loader FSM state encoding and the buffered entry layout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_pkg;

    localparam int AES_BLK_W = 128;

    typedef logic [AES_BLK_W-1:0] aes_blk_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2
    } loader_st_e;

    // One buffered block together with its encrypt/decrypt selector.
    typedef struct packed {
        logic     ende;
        aes_blk_t blk;
    } loader_ent_t;

endpackage

`default_nettype wire

// File: rtl/aes_blk_fifo.sv
// ============================================================================
// Module      : aes_blk_fifo
// Description : Synchronous FIFO of loader_ent_t entries with synchronous
//               clear. Push when full and pop when empty are ignored.
//               full/empty reflect the registered occupancy only, so a pop
//               never makes room for a push in the same cycle.
// Ports       : clk, reset_n (async, active low), clear, push, wr_ent,
//               pop, rd_ent (head entry), full, empty
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_blk_fifo
    import aes_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        push,
    input  loader_ent_t wr_ent,
    input  logic        pop,
    output loader_ent_t rd_ent,
    output logic        full,
    output logic        empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    loader_ent_t        r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic               w_do_push;
    logic               w_do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full      = (r_count == CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign rd_ent    = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: occupancy tracking guards every read.
    always_ff @(posedge clk) begin
        if (w_do_push && !clear) begin
            r_mem[r_wr_ptr] <= wr_ent;
        end
    end

endmodule

`default_nettype wire

// File: rtl/aes_blk_loader.sv
// ============================================================================
// Module      : aes_blk_loader
// Description : Upstream feeder for the AES core. Packs WORD_W-bit words into
//               128-bit blocks (first word in the MSBs), buffers blocks in a
//               small FIFO and launches them one at a time, waiting for the
//               core to finish each block before issuing the next.
// Ports       : clk, reset_n (async, active low)
//               s_valid/s_ready/s_data/s_ende/s_last : word stream in
//               flush                                : drop partial + buffered
//               key_ready, core_ready, core_done     : core status
//               core_data_valid, core_data, core_ende: core launch interface
//               pad_evt, blk_issued, err_timeout     : status
// Config      : define AES_LOADER_WDOG_EN to enable the BUSY watchdog
//               (err_timeout after TIMEOUT_CYC cycles without core_done).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_blk_loader
    import aes_pkg::*;
#(
    parameter int WORD_W      = 32,   // 32 or 64
    parameter int FIFO_DEPTH  = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [WORD_W-1:0]    s_data,
    input  logic                 s_ende,
    input  logic                 s_last,
    input  logic                 flush,
    input  logic                 key_ready,
    input  logic                 core_ready,
    input  logic                 core_done,
    output logic                 core_data_valid,
    output logic [AES_BLK_W-1:0] core_data,
    output logic                 core_ende,
    output logic                 pad_evt,
    output logic [15:0]          blk_issued,
    output logic                 err_timeout
);

    localparam int WPB   = AES_BLK_W / WORD_W;
    localparam int IDX_W = (WPB > 1) ? $clog2(WPB) : 1;

    // ------------------------------------------------------------------
    // Word packing
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] r_word_idx;
    aes_blk_t         r_pack;
    logic             r_ende_hold;
    logic             r_pad_evt;

    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic             w_last_word;
    logic             w_close;
    logic             w_accept;
    logic             w_commit;
    logic             w_pad;
    logic             w_ende_cur;
    aes_blk_t         w_blk_next;
    loader_ent_t      w_wr_ent;
    loader_ent_t      w_rd_ent;

    assign w_last_word = (r_word_idx == IDX_W'(WPB - 1));
    assign w_close     = w_last_word || s_last;

    // Any block-closing word (full or s_last-padded) needs a free entry;
    // the registered full flag is used so there is no path from the pop.
    assign s_ready     = !flush && !(w_close && w_fifo_full);
    assign w_accept    = s_valid && s_ready;
    assign w_commit    = w_accept && w_close;
    assign w_pad       = w_commit && !w_last_word;

    // Direction is captured with the first word and held for the block.
    assign w_ende_cur  = (r_word_idx == '0) ? s_ende : r_ende_hold;

    // Partial block with the current word merged in; words not yet
    // written stay zero because r_pack is cleared after every commit.
    always_comb begin
        w_blk_next = r_pack;
        for (int k = 0; k < WPB; k++) begin
            if (r_word_idx == IDX_W'(k)) begin
                w_blk_next[AES_BLK_W-1-k*WORD_W -: WORD_W] = s_data;
            end
        end
    end

    assign w_wr_ent.ende = w_ende_cur;
    assign w_wr_ent.blk  = w_blk_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_word_idx  <= '0;
            r_pack      <= '0;
            r_ende_hold <= 1'b0;
            r_pad_evt   <= 1'b0;
        end else begin
            r_pad_evt <= w_pad;
            if (flush) begin
                r_word_idx <= '0;
                r_pack     <= '0;
            end else if (w_accept) begin
                if (w_close) begin
                    r_word_idx <= '0;
                    r_pack     <= '0;
                end else begin
                    r_word_idx  <= r_word_idx + IDX_W'(1);
                    r_pack      <= w_blk_next;
                    r_ende_hold <= w_ende_cur;
                end
            end
        end
    end

    assign pad_evt = r_pad_evt;

    // ------------------------------------------------------------------
    // Block buffer
    // ------------------------------------------------------------------
    loader_st_e r_state;
    loader_st_e w_state_nxt;
    logic       w_issue_go;
    logic       w_pop;
    logic       w_timeout;

    aes_blk_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (flush),
        .push    (w_commit),
        .wr_ent  (w_wr_ent),
        .pop     (w_pop),
        .rd_ent  (w_rd_ent),
        .full    (w_fifo_full),
        .empty   (w_fifo_empty)
    );

    // ------------------------------------------------------------------
    // Issue FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_issue_go  = 1'b0;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_fifo_empty && key_ready && core_ready) begin
                    w_state_nxt = ISSUE;
                    w_issue_go  = 1'b1;
                end
            end
            ISSUE: begin
                w_pop       = 1'b1;
                w_state_nxt = BUSY;
            end
            BUSY: begin
                if (core_done || w_timeout) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Launch data is captured on the edge entering ISSUE and held through
    // BUSY so core_ende stays stable until the core finishes.
    logic [AES_BLK_W-1:0] r_core_data;
    logic                 r_core_ende;
    logic [15:0]          r_blk_issued;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_core_data  <= '0;
            r_core_ende  <= 1'b0;
            r_blk_issued <= '0;
        end else if (w_issue_go) begin
            r_core_data  <= w_rd_ent.blk;
            r_core_ende  <= w_rd_ent.ende;
            r_blk_issued <= r_blk_issued + 16'd1;
        end
    end

    assign core_data_valid = (r_state == ISSUE);
    assign core_data       = r_core_data;
    assign core_ende       = r_core_ende;
    assign blk_issued      = r_blk_issued;

    // ------------------------------------------------------------------
    // Optional BUSY watchdog
    // ------------------------------------------------------------------
`ifdef AES_LOADER_WDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [WD_W-1:0] r_wdog_cnt;
    logic            r_err_timeout;

    // Counts BUSY cycles; fires on the TIMEOUT_CYC-th one without core_done.
    assign w_timeout = (r_state == BUSY) && !core_done &&
                       (r_wdog_cnt == WD_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wdog_cnt    <= '0;
            r_err_timeout <= 1'b0;
        end else begin
            if (r_state == BUSY && !w_timeout) begin
                r_wdog_cnt <= r_wdog_cnt + WD_W'(1);
            end else begin
                r_wdog_cnt <= '0;
            end
            if (w_timeout) begin
                r_err_timeout <= 1'b1;
            end
        end
    end

    assign err_timeout = r_err_timeout;
`else
    logic w_unused_timeout_cfg;

    assign w_unused_timeout_cfg = ^TIMEOUT_CYC;
    assign w_timeout            = 1'b0;
    assign err_timeout          = 1'b0;
`endif

endmodule

`default_nettype wire
